// File: rtl/execute_stage_div.sv
// Execute stage: registers the decode payload, runs the iterative divider,
// finalises the result and issues the data SRAM request.
module execute_stage_div #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_en,
  input  logic        ms_ex_pending,
  input  logic        DE_valid,
  output logic        E_allowin,
  input  logic [31:0] de_pc,
  input  logic [31:0] de_src1,
  input  logic [31:0] de_src2,
  input  logic [31:0] de_alu_result,
  input  logic        de_div_en,
  input  logic        de_div_signed,
  input  logic        de_div_mod,
  input  logic        de_mem_we,
  input  logic [3:0]  de_res_from_mem,
  input  logic [1:0]  de_mem_size,
  input  logic [31:0] de_store_data,
  input  logic        de_gr_we,
  input  logic [4:0]  de_dest,
  input  logic        de_ex,
  input  logic        M_allowin,
  output logic        EM_valid,
  output logic [31:0] em_pc,
  output logic [31:0] em_result,
  output logic        em_gr_we,
  output logic [4:0]  em_dest,
  output logic [3:0]  em_res_from_mem,
  output logic [31:0] em_vaddr,
  output logic        em_ex,
  output logic        em_ale,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [4:0]  ED_dest,
  output logic [31:0] ED_result,
  output logic        ED_busy
);

  localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  logic        e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_src1;
  logic [31:0] e_src2;
  logic [31:0] e_alu_result;
  logic        e_div_en;
  logic        e_div_signed;
  logic        e_div_mod;
  logic        e_mem_we;
  logic [3:0]  e_res_from_mem;
  logic [1:0]  e_mem_size;
  logic [31:0] e_store_data;
  logic        e_gr_we;
  logic [4:0]  e_dest;
  logic        e_ex;

  div_state_t  div_state;
  logic [CW-1:0] div_cnt;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [31:0] div_dvs;

  logic        ex_any;
  logic        div_pending;
  logic        e_ready_go;
  logic        handoff;

  logic        src1_neg;
  logic        src2_neg;
  logic [31:0] src1_abs;
  logic [31:0] src2_abs;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  logic [32:0] div_shifted;
  logic        div_fits;
  logic [31:0] div_rem_next;
  logic [31:0] div_quo_next;

  logic        mem_op;
  logic        is_half;
  logic        is_word;
  logic        ale;
  logic [3:0]  we_raw;

  // Handshake
  assign ex_any      = e_ex || ex_en;
  assign div_pending = e_div_en && e_valid && !e_ex;
  assign e_ready_go  = !div_pending || (div_state == DIV_DONE);
  assign E_allowin   = !e_valid || (e_ready_go && M_allowin);
  assign EM_valid    = e_valid && e_ready_go;
  assign handoff     = EM_valid && M_allowin;

  // Operand magnitudes and sign fix-up
  assign src1_neg = e_div_signed && e_src1[31];
  assign src2_neg = e_div_signed && e_src2[31];
  assign src1_abs = src1_neg ? (~e_src1 + 32'd1) : e_src1;
  assign src2_abs = src2_neg ? (~e_src2 + 32'd1) : e_src2;
  // A zero divisor already yields an all-ones quotient and |src1| as the
  // remainder, so only the quotient negation has to be suppressed for it.
  assign neg_q   = (src1_neg ^ src2_neg) && (e_src2 != '0);
  assign neg_r   = src1_neg;
  assign quo_fix = neg_q ? (~div_quo + 32'd1) : div_quo;
  assign rem_fix = neg_r ? (~div_rem + 32'd1) : div_rem;

  // One restoring step; the true difference always fits in 32 bits
  assign div_shifted  = {div_rem, div_quo[31]};
  assign div_fits     = div_shifted >= {1'b0, div_dvs};
  assign div_rem_next = div_fits ? (div_shifted[31:0] - div_dvs) : div_shifted[31:0];
  assign div_quo_next = {div_quo[30:0], div_fits};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      e_valid        <= 1'b0;
      e_pc           <= '0;
      e_src1         <= '0;
      e_src2         <= '0;
      e_alu_result   <= '0;
      e_div_en       <= 1'b0;
      e_div_signed   <= 1'b0;
      e_div_mod      <= 1'b0;
      e_mem_we       <= 1'b0;
      e_res_from_mem <= '0;
      e_mem_size     <= '0;
      e_store_data   <= '0;
      e_gr_we        <= 1'b0;
      e_dest         <= '0;
      e_ex           <= 1'b0;
    end else begin
      if (ex_en) begin
        e_valid <= 1'b0;
      end else if (E_allowin) begin
        e_valid <= DE_valid;
      end
      if (DE_valid && E_allowin) begin
        e_pc           <= de_pc;
        e_src1         <= de_src1;
        e_src2         <= de_src2;
        e_alu_result   <= de_alu_result;
        e_div_en       <= de_div_en;
        e_div_signed   <= de_div_signed;
        e_div_mod      <= de_div_mod;
        e_mem_we       <= de_mem_we;
        e_res_from_mem <= de_res_from_mem;
        e_mem_size     <= de_mem_size;
        e_store_data   <= de_store_data;
        e_gr_we        <= de_gr_we;
        e_dest         <= de_dest;
        e_ex           <= de_ex;
      end
    end
  end

  // BUSY spends one extra cycle at cnt==DIV_CYCLES registering the sign
  // fix-up, which keeps the negation adders off the result output path.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_state <= DIV_IDLE;
      div_cnt   <= '0;
      div_quo   <= '0;
      div_rem   <= '0;
      div_dvs   <= '0;
    end else if (ex_en) begin
      div_state <= DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (e_valid && e_div_en && !ex_any) begin
            div_quo   <= src1_abs;
            div_dvs   <= src2_abs;
            div_rem   <= '0;
            div_cnt   <= '0;
            div_state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (div_cnt == CW'(DIV_CYCLES)) begin
            div_quo   <= quo_fix;
            div_rem   <= rem_fix;
            div_state <= DIV_DONE;
          end else begin
            div_quo <= div_quo_next;
            div_rem <= div_rem_next;
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DIV_DONE: begin
          if (handoff) begin
            div_state <= DIV_IDLE;
          end
        end
        default: div_state <= DIV_IDLE;
      endcase
    end
  end

  // Memory access decode
  assign mem_op  = e_mem_we || (|e_res_from_mem);
  assign is_half = e_mem_we ? (e_mem_size == 2'd1) : e_res_from_mem[1];
  assign is_word = e_mem_we ? (e_mem_size == 2'd2) : e_res_from_mem[3];
  assign ale     = mem_op && ((is_half && e_alu_result[0]) ||
                              (is_word && (|e_alu_result[1:0])));

  always_comb begin
    we_raw          = 4'b0000;
    data_sram_wdata = e_store_data;
    case (e_mem_size)
      2'd0: begin
        we_raw          = 4'b0001 << e_alu_result[1:0];
        data_sram_wdata = {4{e_store_data[7:0]}};
      end
      2'd1: begin
        we_raw          = e_alu_result[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{e_store_data[15:0]}};
      end
      default: begin
        we_raw          = 4'b1111;
        data_sram_wdata = e_store_data;
      end
    endcase
  end

  assign em_ex          = e_ex || ale;
  assign em_ale         = ale;
  assign data_sram_en   = e_valid && mem_op && !em_ex && !ex_en;
  assign data_sram_we   = (data_sram_en && e_mem_we && !ms_ex_pending) ? we_raw : 4'b0000;
  assign data_sram_addr = e_alu_result;

  // Payload to M and forwarding
  assign em_pc           = e_pc;
  assign em_result       = e_div_en ? (e_div_mod ? div_rem : div_quo) : e_alu_result;
  assign em_gr_we        = e_gr_we;
  assign em_dest         = e_dest;
  assign em_res_from_mem = e_res_from_mem;
  assign em_vaddr        = e_alu_result;

  assign ED_dest   = (e_valid && e_gr_we) ? e_dest : 5'd0;
  assign ED_result = em_result;
  assign ED_busy   = e_valid && ((|e_res_from_mem) || (e_div_en && (div_state != DIV_DONE)));

endmodule

// File: tb/tb_execute_stage_div.sv
// Directed bench for execute_stage_div: handoffs are checked against a queue
// of expected payloads filled as each instruction is issued.
module tb_execute_stage_div;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ex_en = 1'b0;
  logic        ms_ex_pending = 1'b0;
  logic        DE_valid = 1'b0;
  logic        E_allowin;
  logic [31:0] de_pc, de_src1, de_src2, de_alu_result, de_store_data;
  logic        de_div_en, de_div_signed, de_div_mod, de_mem_we, de_gr_we, de_ex;
  logic [3:0]  de_res_from_mem;
  logic [1:0]  de_mem_size;
  logic [4:0]  de_dest;
  logic        M_allowin = 1'b1;
  logic        EM_valid;
  logic [31:0] em_pc, em_result, em_vaddr;
  logic        em_gr_we, em_ex, em_ale;
  logic [4:0]  em_dest;
  logic [3:0]  em_res_from_mem;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [4:0]  ED_dest;
  logic [31:0] ED_result;
  logic        ED_busy;

  execute_stage_div #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rstn(rstn), .ex_en(ex_en), .ms_ex_pending(ms_ex_pending),
    .DE_valid(DE_valid), .E_allowin(E_allowin),
    .de_pc(de_pc), .de_src1(de_src1), .de_src2(de_src2), .de_alu_result(de_alu_result),
    .de_div_en(de_div_en), .de_div_signed(de_div_signed), .de_div_mod(de_div_mod),
    .de_mem_we(de_mem_we), .de_res_from_mem(de_res_from_mem), .de_mem_size(de_mem_size),
    .de_store_data(de_store_data), .de_gr_we(de_gr_we), .de_dest(de_dest), .de_ex(de_ex),
    .M_allowin(M_allowin), .EM_valid(EM_valid), .em_pc(em_pc), .em_result(em_result),
    .em_gr_we(em_gr_we), .em_dest(em_dest), .em_res_from_mem(em_res_from_mem),
    .em_vaddr(em_vaddr), .em_ex(em_ex), .em_ale(em_ale),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .ED_dest(ED_dest), .ED_result(ED_result), .ED_busy(ED_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        ex;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    bit          md;
    logic [31:0] res;
  } dcase_t;

  exp_t   sbq[$];
  dcase_t dc[$];
  int tests = 0;
  int fails = 0;
  int handoffs = 0;
  int pushed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn, input bit md);
    longint da, db, q, r;
    if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      da = longint'($signed(a));
      db = longint'($signed(b));
    end else begin
      da = {32'd0, a};
      db = {32'd0, b};
    end
    q = da / db;
    r = da % db;
    return md ? r[31:0] : q[31:0];
  endfunction

  // Scoreboard: every handoff to M must match the oldest pending expectation
  always @(negedge clk) begin
    if (rstn && EM_valid && M_allowin) begin
      handoffs++;
      tests++;
      assert (sbq.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_handoff observed pc=0x%08h expected=no handoff", em_pc);
      end
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("handoff_pc", em_pc, e.pc);
        check("handoff_result", em_result, e.result);
        check("handoff_dest", em_dest, e.dest);
        check("handoff_ex", em_ex, e.ex);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_de();
    de_pc = '0; de_src1 = '0; de_src2 = '0; de_alu_result = '0; de_store_data = '0;
    de_div_en = 0; de_div_signed = 0; de_div_mod = 0; de_mem_we = 0; de_gr_we = 0;
    de_ex = 0; de_res_from_mem = '0; de_mem_size = 2'd2; de_dest = '0;
  endtask

  task automatic set_div(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input bit sgn, input bit md, input logic [4:0] dest);
    clr_de();
    de_pc = pc; de_src1 = a; de_src2 = b; de_div_en = 1; de_div_signed = sgn;
    de_div_mod = md; de_gr_we = 1; de_dest = dest;
  endtask

  task automatic set_mem(input logic [31:0] pc, input logic [31:0] addr, input bit we,
                         input logic [3:0] rfm, input logic [1:0] size,
                         input logic [31:0] sd, input logic [4:0] dest);
    clr_de();
    de_pc = pc; de_alu_result = addr; de_mem_we = we; de_res_from_mem = rfm;
    de_mem_size = size; de_store_data = sd; de_gr_we = !we; de_dest = we ? 5'd0 : dest;
  endtask

  // Holds DE_valid until the stage accepts; returns 1 ns after the capture edge
  task automatic issue(input bit push, input logic [31:0] exp_res, input bit exp_ex);
    bit ok = 0;
    if (push) begin
      sbq.push_back('{de_pc, exp_res, de_dest, exp_ex});
      pushed++;
    end
    DE_valid = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = E_allowin;
      tick();
      if (ok) break;
    end
    check("issue_accepted", 32'(ok), 32'd1);
    DE_valid = 0;
  endtask

  task automatic wait_em(input int exp_lat);
    int lat = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (EM_valid) begin
        lat = k;
        break;
      end
    end
    check("div_latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    clr_de();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_E_allowin", E_allowin, 1);
    check("rst_EM_valid", EM_valid, 0);
    check("rst_sram_en", data_sram_en, 0);
    check("rst_sram_we", data_sram_we, 0);
    check("rst_ED_busy", ED_busy, 0);
    check("rst_ED_dest", ED_dest, 0);
    check("rst_em_result", em_result, 0);
    check("rst_em_pc", em_pc, 0);
    tick();
    rstn = 1;
    tick();

    // DIV.W -7 / 2 with stage status during and after the divide
    set_div(32'h100, 32'hFFFF_FFF9, 32'd2, 1, 0, 5'd3);
    issue(1, 32'hFFFF_FFFD, 0);
    check("div_busy", ED_busy, 1);
    check("div_allowin", E_allowin, 0);
    check("div_ED_dest", ED_dest, 3);
    check("div_EM_valid_early", EM_valid, 0);
    wait_em(34);
    check("div_done_busy", ED_busy, 0);
    check("div_ED_result", ED_result, 32'hFFFF_FFFD);

    dc.push_back('{32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1, 32'hFFFF_FFFF});
    dc.push_back('{32'h8000_0000, 32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF});
    dc.push_back('{32'h8000_0000, 32'd0,         1'b0, 1'b1, 32'h8000_0000});
    dc.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000});
    dc.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000});
    dc.push_back('{32'hFFFF_FFFB, 32'd0,         1'b1, 1'b0, 32'hFFFF_FFFF});
    dc.push_back('{32'hFFFF_FFFB, 32'd0,         1'b1, 1'b1, 32'hFFFF_FFFB});
    dc.push_back('{32'd100,       32'hFFFF_FFF9, 1'b1, 1'b1, 32'd2});
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      bit sgn, md;
      a = $urandom; b = $urandom_range(1, 5000); sgn = 1'(i); md = 1'(i >> 1);
      dc.push_back('{a, b, sgn, md, div_model(a, b, sgn, md)});
    end
    foreach (dc[i]) begin
      set_div(32'h104 + 32'(4 * i), dc[i].a, dc[i].b, dc[i].sgn, dc[i].md, 5'(i + 8));
      issue(1, dc[i].res, 0);
      wait_em(34);
    end

    // Stores and loads
    set_mem(32'h200, 32'h1002, 1, 4'b0000, 2'd1, 32'h1234_ABCD, 0);
    issue(1, 32'h1002, 0);
    check("sth_en", data_sram_en, 1);
    check("sth_we", data_sram_we, 4'b1100);
    check("sth_wdata", data_sram_wdata, 32'hABCD_ABCD);
    check("sth_addr", data_sram_addr, 32'h1002);
    check("sth_ale", em_ale, 0);

    set_mem(32'h204, 32'h1003, 1, 4'b0000, 2'd0, 32'h0000_00EF, 0);
    issue(1, 32'h1003, 0);
    check("stb_we", data_sram_we, 4'b1000);
    check("stb_wdata", data_sram_wdata, 32'hEFEF_EFEF);

    ms_ex_pending = 1;
    set_mem(32'h208, 32'h1004, 1, 4'b0000, 2'd2, 32'hCAFE_F00D, 0);
    issue(1, 32'h1004, 0);
    check("stw_pending_en", data_sram_en, 1);
    check("stw_pending_we", data_sram_we, 4'b0000);
    ms_ex_pending = 0;
    #1;
    check("stw_we", data_sram_we, 4'b1111);
    check("stw_wdata", data_sram_wdata, 32'hCAFE_F00D);

    set_mem(32'h20C, 32'h1001, 1, 4'b0000, 2'd1, 32'h5555_AAAA, 0);
    issue(1, 32'h1001, 1);
    check("sth_mis_ale", em_ale, 1);
    check("sth_mis_en", data_sram_en, 0);
    check("sth_mis_we", data_sram_we, 4'b0000);

    set_mem(32'h210, 32'h1001, 0, 4'b1000, 2'd2, 0, 5'd4);
    issue(1, 32'h1001, 1);
    check("ldw_mis_ale", em_ale, 1);
    check("ldw_mis_ex", em_ex, 1);
    check("ldw_mis_en", data_sram_en, 0);

    set_mem(32'h214, 32'h1002, 0, 4'b0010, 2'd1, 0, 5'd4);
    issue(1, 32'h1002, 0);
    check("ldh_en", data_sram_en, 1);
    check("ldh_we", data_sram_we, 4'b0000);
    check("ldh_ale", em_ale, 0);
    check("ldh_busy", ED_busy, 1);

    // Flush on the 10th BUSY cycle, then a full-latency restart
    set_div(32'h300, 32'd1000, 32'd10, 1, 0, 5'd6);
    issue(0, 0, 0);
    repeat (10) tick();
    check("flush_pre_busy", ED_busy, 1);
    check("flush_pre_EM_valid", EM_valid, 0);
    ex_en = 1;
    tick();
    ex_en = 0;
    check("flush_EM_valid", EM_valid, 0);
    check("flush_allowin", E_allowin, 1);
    check("flush_busy", ED_busy, 0);
    check("flush_ED_dest", ED_dest, 0);
    set_div(32'h304, 32'd1000, 32'd10, 1, 0, 5'd6);
    issue(1, 32'd100, 0);
    wait_em(34);
    tick();

    // Load stalled by M for three cycles
    M_allowin = 0;
    set_mem(32'h400, 32'h2000, 0, 4'b1000, 2'd2, 0, 5'd5);
    issue(1, 32'h2000, 0);
    clr_de();
    de_pc = 32'h404; de_alu_result = 32'h55; de_gr_we = 1; de_dest = 5'd7;
    sbq.push_back('{de_pc, 32'h55, de_dest, 1'b0});
    pushed++;
    DE_valid = 1;
    h0 = handoffs;
    for (int c = 0; c < 3; c++) begin
      check("stall_allowin", E_allowin, 0);
      check("stall_EM_valid", EM_valid, 1);
      check("stall_pc", em_pc, 32'h400);
      check("stall_sram_en", data_sram_en, 1);
      check("stall_addr", data_sram_addr, 32'h2000);
      if (c < 2) tick();
    end
    M_allowin = 1;
    tick();
    DE_valid = 0;
    check("release_handoffs", 32'(handoffs - h0), 1);
    check("release_next_pc", em_pc, 32'h404);
    check("release_EM_valid", EM_valid, 1);

    repeat (3) tick();
    check("sb_drained", 32'(sbq.size()), 0);
    check("handoff_count", 32'(handoffs), 32'(pushed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
